pipe_stall_ctrl: RTL

//  Central stall sequencer for the 6-entry stall bus (PC,IF,ID,EX,MEM,WB) used by every pipeline register.

---
 rtl/pipe_stall_ctrl_if.sv | 31 +++
 rtl/pipe_stall_ctrl.sv | 129 ++++++++++++
 2 files changed

// File: rtl/pipe_stall_ctrl_if.sv
// Stall-controller bus: hazard sources in, pipeline stall vector and divider/status signals out.
interface pipe_stall_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             id_re1;
    logic [4:0]       id_raddr1;
    logic             id_re2;
    logic [4:0]       id_raddr2;
    logic             ex_is_load;
    logic [4:0]       ex_waddr;
    logic             ex_div_start;
    logic             mem_req;
    logic             mem_ack;
    logic [5:0]       stall;
    logic             div_busy;
    logic             div_done;
    logic             mem_timeout;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_re1, id_raddr1, id_re2, id_raddr2, ex_is_load, ex_waddr,
               ex_div_start, mem_req, mem_ack,
        input  stall, div_busy, div_done, mem_timeout, stall_cnt
    );

    modport slave (
        input  id_re1, id_raddr1, id_re2, id_raddr2, ex_is_load, ex_waddr,
               ex_div_start, mem_req, mem_ack,
        output stall, div_busy, div_done, mem_timeout, stall_cnt
    );
endinterface

// File: rtl/pipe_stall_ctrl.sv
// Central pipeline stall sequencer: merges load-use, divider and data-SRAM wait stalls into one
// 6-bit stall bus (bit0=PC .. bit5=WB), sequences the divider and counts stalled cycles.
module pipe_stall_ctrl #(
    parameter int unsigned DIV_CYCLES = 32,
    parameter int unsigned WAIT_MAX   = 255,
    parameter int unsigned CNT_W      = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    pipe_stall_ctrl_if.slave bus
);
    localparam int unsigned DCNT_W = 6;
    localparam int unsigned WAIT_W = 8;

    localparam logic [5:0] STALL_MEM = 6'b011111;
    localparam logic [5:0] STALL_DIV = 6'b001111;
    localparam logic [5:0] STALL_LD  = 6'b000111;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DIV_RUN  = 2'd1,
        DIV_HOLD = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DCNT_W-1:0]   r_cnt;
    logic [DCNT_W-1:0]   w_cnt_nxt;
    logic [WAIT_W-1:0]   r_wait;
    logic [WAIT_W-1:0]   w_wait_nxt;
    logic                r_timeout;
    logic [CNT_W-1:0]    r_stall_cnt;

    logic                w_ld_hz;
    logic                w_mem_hz;
    logic                w_div_hz;
    logic                w_div_done;
    logic [5:0]          w_stall;

    always_comb begin
        w_ld_hz  = bus.ex_is_load && (bus.ex_waddr != 5'd0) &&
                   ((bus.id_re1 && (bus.id_raddr1 == bus.ex_waddr)) ||
                    (bus.id_re2 && (bus.id_raddr2 == bus.ex_waddr)));
        w_mem_hz = bus.mem_req && !bus.mem_ack;
    end

    // Divider sequencer: start cycle plus DIV_CYCLES-1 counted cycles, then the done cycle
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_div_hz    = 1'b0;
        w_div_done  = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.ex_div_start) begin
                    w_div_hz    = 1'b1;
                    w_state_nxt = DIV_RUN;
                    w_cnt_nxt   = DCNT_W'(DIV_CYCLES - 1);
                end
            end
            DIV_RUN: begin
                if (r_cnt != '0) begin
                    w_div_hz  = 1'b1;
                    w_cnt_nxt = r_cnt - DCNT_W'(1);
                end else if (w_mem_hz) begin
                    w_div_hz    = 1'b1;
                    w_state_nxt = DIV_HOLD;
                end else begin
                    w_div_done  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            DIV_HOLD: begin
                if (w_mem_hz) begin
                    w_div_hz = 1'b1;
                end else begin
                    w_div_done  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Deepest stalled stage wins; lower hazards are re-evaluated once it clears
    always_comb begin
        w_stall = '0;
        if (w_mem_hz) begin
            w_stall = STALL_MEM;
        end else if (w_div_hz) begin
            w_stall = STALL_DIV;
        end else if (w_ld_hz) begin
            w_stall = STALL_LD;
        end
    end

    always_comb begin
        w_wait_nxt = '0;
        if (w_mem_hz) begin
            w_wait_nxt = (r_wait == WAIT_W'(WAIT_MAX)) ? r_wait : r_wait + WAIT_W'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_wait      <= '0;
            r_timeout   <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_wait    <= w_wait_nxt;
            r_timeout <= r_timeout || (w_mem_hz && (w_wait_nxt == WAIT_W'(WAIT_MAX)));
            if ((w_stall != '0) && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.stall       = w_stall;
    assign bus.div_busy    = (r_state != IDLE);
    assign bus.div_done    = w_div_done;
    assign bus.mem_timeout = r_timeout;
    assign bus.stall_cnt   = r_stall_cnt;
endmodule
